// File: rtl/alu_pkg.sv
// Shared encodings for the Small-MIPS ALU control and its multiply/divide unit.
package alu_pkg;

  // aluOp field from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // R-type function codes
  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_NOR   = 6'b100111;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;

  // ALU control codes
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_NOP = 4'b1111;

  // HI/LO read select
  localparam logic [1:0] MDREAD_NONE = 2'b00;
  localparam logic [1:0] MDREAD_HI   = 2'b01;
  localparam logic [1:0] MDREAD_LO   = 2'b10;

  typedef enum logic [1:0] {StIdle, StRun, StFix} mdu_state_e;

  // Matches func[1:0] of the four MDU function codes
  typedef enum logic [1:0] {MdMult, MdMultu, MdDiv, MdDivu} mdu_op_e;

  function automatic logic is_mdu_func(input logic [5:0] func);
    return (func == FUNC_MULT) || (func == FUNC_MULTU) ||
           (func == FUNC_DIV)  || (func == FUNC_DIVU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide datapath: one shift-add or restoring-subtract step per cycle,
// followed by a sign-fix cycle that writes the architectural HI/LO registers.
module mdu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  mdu_op_e          op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic             neg_q;
  logic             rem_neg_q;
  logic             zero_div_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dbz_q;

  // Operand conditioning at accept
  logic             signed_op;
  logic             div_op;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    signed_op = (op_i == MdMult) || (op_i == MdDiv);
    div_op    = (op_i == MdDiv) || (op_i == MdDivu);
    sign_a    = signed_op & src_a_i[WIDTH-1];
    sign_b    = signed_op & src_b_i[WIDTH-1];
    mag_a     = sign_a ? -src_a_i : src_a_i;
    mag_b     = sign_b ? -src_b_i : src_b_i;
  end

  // One iteration step
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    mul_sum  = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, b_q}) : {1'b0, acc_hi_q};
    rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff = {1'b0, rem_sh} - {2'b00, b_q};
    div_ge   = ~div_diff[WIDTH+1];
    if (is_div_q) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitude result
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? -prod : prod;
    if (is_div_q) begin
      // Remainder of a zero divide is the dividend itself, so only LO needs overriding
      fix_hi = rem_neg_q ? -acc_hi_q : acc_hi_q;
      fix_lo = zero_div_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      zero_div_q <= 1'b0;
      b_q        <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            dbz_q      <= 1'b0;
            is_div_q   <= div_op;
            neg_q      <= sign_a ^ sign_b;
            rem_neg_q  <= sign_a;
            zero_div_q <= div_op & (src_b_i == '0);
            acc_hi_q   <= '0;
            if (div_op) begin
              b_q      <= mag_b;
              acc_lo_q <= mag_a;
            end else begin
              b_q      <= mag_a;
              acc_lo_q <= mag_b;
            end
          end
        end
        StRun: begin
          cnt_q    <= cnt_q + CNT_W'(1);
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          if (cnt_q == LastCnt) state_q <= StFix;
        end
        StFix: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          dbz_q   <= zero_div_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode for Small-MIPS plus issue/stall handshake to the multiply/divide unit.
module alu_control_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_aluOp,
  input  logic [5:0]       i_func,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_srcA,
  input  logic [WIDTH-1:0] i_srcB,
  output logic [3:0]       o_aluControl,
  output logic             o_illegal,
  output logic [1:0]       o_mdRead,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_divByZero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic is_mdu;
  logic is_mf;
  logic busy;
  logic start;

  always_comb begin
    o_aluControl = CTRL_NOP;
    o_illegal    = 1'b0;
    o_mdRead     = MDREAD_NONE;
    is_mdu       = 1'b0;
    is_mf        = 1'b0;
    unique case (i_aluOp)
      ALUOP_ADD: o_aluControl = CTRL_ADD;
      ALUOP_SUB: o_aluControl = CTRL_SUB;
      ALUOP_OR:  o_aluControl = CTRL_OR;
      ALUOP_RTYPE: begin
        case (i_func)
          FUNC_ADD: o_aluControl = CTRL_ADD;
          FUNC_SUB: o_aluControl = CTRL_SUB;
          FUNC_AND: o_aluControl = CTRL_AND;
          FUNC_OR:  o_aluControl = CTRL_OR;
          FUNC_SLT: o_aluControl = CTRL_SLT;
          FUNC_NOR: o_aluControl = CTRL_NOR;
          FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: is_mdu = 1'b1;
          FUNC_MFHI: begin
            is_mf    = 1'b1;
            o_mdRead = MDREAD_HI;
          end
          FUNC_MFLO: begin
            is_mf    = 1'b1;
            o_mdRead = MDREAD_LO;
          end
          default: o_illegal = 1'b1;
        endcase
      end
      default: o_aluControl = CTRL_NOP;
    endcase
  end

  // Only instructions that touch HI/LO wait for the unit; everything else flows past it
  assign o_stall = i_valid & busy & (is_mdu | is_mf);
  assign start   = i_valid & is_mdu & ~busy;
  assign o_busy  = busy;

  mdu_core #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mdu_core (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .start_i      (start),
    .op_i         (mdu_op_e'(i_func[1:0])),
    .src_a_i      (i_srcA),
    .src_b_i      (i_srcB),
    .busy_o       (busy),
    .done_o       (o_done),
    .div_by_zero_o(o_divByZero),
    .hi_o         (o_hi),
    .lo_o         (o_lo)
  );

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed-vector bench for alu_control_mdu: decode sweep, MDU results, stall and reset abort.
module tb_alu_control_mdu;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [1:0]   i_aluOp;
  logic [5:0]   i_func;
  logic         i_valid;
  logic [W-1:0] i_srcA;
  logic [W-1:0] i_srcB;
  logic [3:0]   o_aluControl;
  logic         o_illegal;
  logic [1:0]   o_mdRead;
  logic         o_stall;
  logic         o_busy;
  logic         o_done;
  logic         o_divByZero;
  logic [W-1:0] o_hi;
  logic [W-1:0] o_lo;

  int n_vec = 0;
  int n_err = 0;

  alu_control_mdu #(.WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_aluOp     (i_aluOp),
    .i_func      (i_func),
    .i_valid     (i_valid),
    .i_srcA      (i_srcA),
    .i_srcB      (i_srcB),
    .o_aluControl(o_aluControl),
    .o_illegal   (o_illegal),
    .o_mdRead    (o_mdRead),
    .o_stall     (o_stall),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_divByZero (o_divByZero),
    .o_hi        (o_hi),
    .o_lo        (o_lo)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // exp = {illegal, mdRead[1:0], aluControl[3:0]}
  task automatic dec(input string tag, input logic [1:0] op, input logic [5:0] func,
                     input logic [6:0] exp);
    i_aluOp = op;
    i_func  = func;
    #1;
    chk(tag, {57'd0, o_illegal, o_mdRead, o_aluControl}, {57'd0, exp});
  endtask

  task automatic run_mdu(input string tag, input logic [5:0] func, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input logic exp_dbz);
    int n;
    i_valid = 1'b1;
    i_aluOp = ALUOP_RTYPE;
    i_func  = func;
    i_srcA  = a;
    i_srcB  = b;
    #1;
    chk({tag, " stall_at_issue"}, 64'(o_stall), 64'd0);
    step();
    i_valid = 1'b0;
    i_aluOp = ALUOP_ADD;
    i_func  = 6'd0;
    chk({tag, " busy_after_accept"}, 64'(o_busy), 64'd1);
    chk({tag, " dbz_cleared"}, 64'(o_divByZero), 64'd0);
    n = 0;
    while (o_busy && n < 100) begin
      step();
      n++;
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'(W + 1));
    chk({tag, " done"}, 64'(o_done), 64'd1);
    chk({tag, " hi"}, 64'(o_hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(o_lo), 64'(exp_lo));
    chk({tag, " dbz"}, 64'(o_divByZero), 64'(exp_dbz));
    step();
    chk({tag, " done_one_cycle"}, 64'(o_done), 64'd0);
  endtask

  initial begin
    int n;
    int dones;
    i_rst   = 1'b1;
    i_aluOp = ALUOP_ADD;
    i_func  = 6'd0;
    i_valid = 1'b0;
    i_srcA  = '0;
    i_srcB  = '0;
    step();
    step();
    chk("reset busy", 64'(o_busy), 64'd0);
    chk("reset done", 64'(o_done), 64'd0);
    chk("reset dbz", 64'(o_divByZero), 64'd0);
    chk("reset hilo", {o_hi, o_lo}, 64'd0);
    i_rst = 1'b0;
    step();

    dec("dec add",   2'b00, 6'b000000, 7'b0_00_0010);
    dec("dec sub",   2'b01, 6'b101010, 7'b0_00_0110);
    dec("dec or",    2'b11, 6'b111111, 7'b0_00_0001);
    dec("dec radd",  2'b10, 6'b100000, 7'b0_00_0010);
    dec("dec rsub",  2'b10, 6'b100010, 7'b0_00_0110);
    dec("dec rand",  2'b10, 6'b100100, 7'b0_00_0000);
    dec("dec ror",   2'b10, 6'b100101, 7'b0_00_0001);
    dec("dec rslt",  2'b10, 6'b101010, 7'b0_00_0111);
    dec("dec rnor",  2'b10, 6'b100111, 7'b0_00_1100);
    dec("dec mult",  2'b10, 6'b011000, 7'b0_00_1111);
    dec("dec multu", 2'b10, 6'b011001, 7'b0_00_1111);
    dec("dec div",   2'b10, 6'b011010, 7'b0_00_1111);
    dec("dec divu",  2'b10, 6'b011011, 7'b0_00_1111);
    dec("dec mfhi",  2'b10, 6'b010000, 7'b0_01_1111);
    dec("dec mflo",  2'b10, 6'b010010, 7'b0_10_1111);
    dec("dec bad",   2'b10, 6'b111111, 7'b1_00_1111);
    chk("no accept without valid", 64'(o_busy), 64'd0);

    run_mdu("mult 7*-3",    FUNC_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_mdu("multu",        FUNC_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_mdu("div -7/2",     FUNC_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_mdu("divu 100/7",   FUNC_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0);
    run_mdu("div min/-1",   FUNC_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_mdu("divu 5/0",     FUNC_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1);
    run_mdu("mult -1*-1",   FUNC_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);

    // MFLO behind a running MULT, with an unrelated add slipping through
    i_valid = 1'b1;
    i_aluOp = ALUOP_RTYPE;
    i_func  = FUNC_MULTU;
    i_srcA  = 32'h00010000;
    i_srcB  = 32'h00010000;
    step();
    i_valid = 1'b0;
    step();
    step();
    step();
    i_valid = 1'b1;
    i_func  = FUNC_MFLO;
    #1;
    chk("mflo stall", 64'(o_stall), 64'd1);
    chk("mflo mdRead", 64'(o_mdRead), 64'(MDREAD_LO));
    i_aluOp = ALUOP_ADD;
    i_func  = FUNC_ADD;
    #1;
    chk("add no stall", 64'(o_stall), 64'd0);
    step();
    chk("add hilo untouched", {o_hi, o_lo}, 64'h00000000_00000001);
    i_aluOp = ALUOP_RTYPE;
    i_func  = FUNC_MFLO;
    #1;
    n = 0;
    while (o_stall && n < 100) begin
      step();
      n++;
    end
    chk("mflo stall cycles", 64'(n), 64'd29);
    chk("mflo release on done", 64'(o_done), 64'd1);
    chk("stalled mult hilo", {o_hi, o_lo}, 64'h00000001_00000000);
    i_valid = 1'b0;
    i_aluOp = ALUOP_ADD;
    i_func  = 6'd0;
    step();

    // Reset in the middle of a divide aborts it
    i_valid = 1'b1;
    i_aluOp = ALUOP_RTYPE;
    i_func  = FUNC_DIV;
    i_srcA  = 32'd100;
    i_srcB  = 32'd7;
    step();
    i_valid = 1'b0;
    i_aluOp = ALUOP_ADD;
    i_func  = 6'd0;
    repeat (10) step();
    i_rst = 1'b1;
    #1;
    chk("abort busy", 64'(o_busy), 64'd0);
    chk("abort done", 64'(o_done), 64'd0);
    chk("abort hilo", {o_hi, o_lo}, 64'd0);
    step();
    i_rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_done) dones++;
    end
    chk("no done after abort", 64'(dones), 64'd0);
    chk("idle after abort", 64'(o_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
